trellis_bank_ctrl: RTL and testbench

Address and bank sequencer for the Viterbi decoder's storage path. It rotates the four survivor (trellis) memory banks A–D through write and traceback-read roles, and generates their registered addresses and write strobes. It also drives the two traceback units' enables, bank-source selects and selection bits, and ping-pongs the two display memories. It sits beside the ACS array and owns every counter and bank-role decision; the decoder top holds only the memories, TBUs and data muxes.

---
 rtl/trellis_bank_ctrl_if.sv | 30 +++
 rtl/trellis_bank_ctrl.sv | 140 ++++++++++++++
 tb/tb_trellis_bank_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trellis_bank_ctrl_if.sv
// Bus between trellis_bank_ctrl and the decoder top: decode enable in; bank addresses,
// write strobes, TBU controls, display-memory addressing and status out.
interface trellis_bank_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              enable;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c, addr_d;
  logic              wr_a, wr_b, wr_c, wr_d;
  logic              tbu0_en, tbu1_en;
  logic [1:0]        tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1;
  logic              tbu0_sel, tbu1_sel;
  logic [ADDR_W-1:0] addr_disp0, addr_disp1;
  logic              out_sel;
  logic [1:0]        state_o;
  logic [15:0]       frame_cnt;

  modport master (
    input  enable,
    output addr_a, addr_b, addr_c, addr_d, wr_a, wr_b, wr_c, wr_d,
           tbu0_en, tbu1_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1,
           tbu0_sel, tbu1_sel, addr_disp0, addr_disp1, out_sel, state_o, frame_cnt
  );

  modport slave (
    output enable,
    input  addr_a, addr_b, addr_c, addr_d, wr_a, wr_b, wr_c, wr_d,
           tbu0_en, tbu1_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1,
           tbu0_sel, tbu1_sel, addr_disp0, addr_disp1, out_sel, state_o, frame_cnt
  );
endinterface

// File: rtl/trellis_bank_ctrl.sv
// Viterbi storage-path sequencer: rotates trellis banks A-D, drives TBU controls and
// ping-pongs display memories. Define FRAME_CNT_EN to build the bank-rotation counter.
module trellis_bank_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  trellis_bank_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] CNT_MAX      = '1;
  localparam logic [ADDR_W-1:0] DISP_WR_INIT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] DISP_RD_INIT = CNT_MAX - ADDR_W'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_cnt, rd_cnt, disp_wr_cnt, disp_rd_cnt;
  logic [1:0]        bank, bank_d1, bank_d2;
  logic              disp_ph, disp_ph_d1;
  logic              wrap;
  logic [ADDR_W-1:0] addr_nxt [4];
  logic [3:0]        wr_nxt;
  logic [1:0]        t0s0, t0s1, t1s0, t1s1;
  logic              t0sel, t1sel;

  assign wrap        = (wr_cnt == CNT_MAX);
  assign bus.state_o = state;

  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (bank_d2 == 2'd2) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Writer takes bank index; the bank opposite it (index ^ 2) idles; the other two read.
  always_comb begin
    addr_nxt = '{default: '0};
    wr_nxt   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (2'(i) == bank) begin
        addr_nxt[i] = wr_cnt;
        wr_nxt[i]   = 1'b1;
      end else if (2'(i) != (bank ^ 2'd2)) begin
        addr_nxt[i] = rd_cnt;
      end
    end
  end

  always_comb begin
    t0s0 = 2'd3; t0s1 = 2'd2; t0sel = 1'b0;
    t1s0 = 2'd2; t1s1 = 2'd1; t1sel = 1'b1;
    case (bank_d2)
      2'd0: begin t0s0 = 2'd3; t0s1 = 2'd2; t0sel = 1'b0; t1s0 = 2'd2; t1s1 = 2'd1; t1sel = 1'b1; end
      2'd1: begin t0s0 = 2'd3; t0s1 = 2'd2; t0sel = 1'b1; t1s0 = 2'd0; t1s1 = 2'd3; t1sel = 1'b0; end
      2'd2: begin t0s0 = 2'd1; t0s1 = 2'd0; t0sel = 1'b0; t1s0 = 2'd0; t1s1 = 2'd3; t1sel = 1'b1; end
      default: begin t0s0 = 2'd1; t0s1 = 2'd0; t0sel = 1'b1; t1s0 = 2'd2; t1s1 = 2'd1; t1sel = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= CNT_MAX;
      disp_wr_cnt <= DISP_WR_INIT;
      disp_rd_cnt <= DISP_RD_INIT;
      bank        <= '0;
      bank_d1     <= '0;
      bank_d2     <= '0;
      disp_ph     <= 1'b0;
      disp_ph_d1  <= 1'b0;
      bus.out_sel <= 1'b0;
      bus.addr_a  <= '0; bus.addr_b <= '0; bus.addr_c <= '0; bus.addr_d <= '0;
      bus.wr_a    <= 1'b0; bus.wr_b <= 1'b0; bus.wr_c <= 1'b0; bus.wr_d <= 1'b0;
      bus.tbu0_en <= 1'b0; bus.tbu1_en <= 1'b0;
      bus.tbu0_src0 <= '0; bus.tbu0_src1 <= '0; bus.tbu0_sel <= 1'b0;
      bus.tbu1_src0 <= '0; bus.tbu1_src1 <= '0; bus.tbu1_sel <= 1'b0;
      bus.addr_disp0 <= '0; bus.addr_disp1 <= '0;
    end else begin
      state         <= state_nxt;
      disp_ph_d1    <= disp_ph;
      bus.out_sel   <= disp_ph_d1;
      bus.tbu0_src0 <= t0s0; bus.tbu0_src1 <= t0s1; bus.tbu0_sel <= t0sel;
      bus.tbu1_src0 <= t1s0; bus.tbu1_src1 <= t1s1; bus.tbu1_sel <= t1sel;
      // Flush restarts the stream but leaves every address output at its last value.
      if (!bus.enable) begin
        wr_cnt      <= '0;
        rd_cnt      <= CNT_MAX;
        disp_wr_cnt <= DISP_WR_INIT;
        disp_rd_cnt <= DISP_RD_INIT;
        bank        <= '0;
        bank_d1     <= '0;
        bank_d2     <= '0;
        disp_ph     <= 1'b0;
        bus.wr_a    <= 1'b0; bus.wr_b <= 1'b0; bus.wr_c <= 1'b0; bus.wr_d <= 1'b0;
        bus.tbu0_en <= 1'b0; bus.tbu1_en <= 1'b0;
      end else begin
        wr_cnt      <= wr_cnt + 1'b1;
        rd_cnt      <= rd_cnt - 1'b1;
        disp_wr_cnt <= disp_wr_cnt - 1'b1;
        disp_rd_cnt <= disp_rd_cnt + 1'b1;
        bank        <= bank + {1'b0, wrap};
        bank_d1     <= bank;
        bank_d2     <= bank_d1;
        disp_ph     <= bank_d2[0];
        bus.addr_a  <= addr_nxt[0]; bus.addr_b <= addr_nxt[1];
        bus.addr_c  <= addr_nxt[2]; bus.addr_d <= addr_nxt[3];
        bus.wr_a    <= wr_nxt[0]; bus.wr_b <= wr_nxt[1];
        bus.wr_c    <= wr_nxt[2]; bus.wr_d <= wr_nxt[3];
        bus.tbu0_en <= bus.tbu0_en | (bank_d2 == 2'd2);
        bus.tbu1_en <= bus.tbu1_en | (bank_d2 == 2'd3);
        bus.addr_disp0 <= disp_ph ? disp_wr_cnt : disp_rd_cnt;
        bus.addr_disp1 <= disp_ph ? disp_rd_cnt : disp_wr_cnt;
      end
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_q;
  always_ff @(posedge clk) begin
    if (!rst || !bus.enable) begin
      frame_q <= '0;
    end else if (wrap && bank == 2'd3 && frame_q != 16'hFFFF) begin
      frame_q <= frame_q + 16'd1;
    end
  end
  assign bus.frame_cnt = frame_q;
`else
  assign bus.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_trellis_bank_ctrl.sv
// Directed bench for trellis_bank_ctrl (ADDR_W=10): reset values, bank rotation,
// TBU startup/routing, display ping-pong, flush at wrap, mid-frame reset.
module tb_trellis_bank_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  trellis_bank_ctrl_if #(.ADDR_W(10)) bus ();
  trellis_bank_ctrl #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  // Role and routing tables, indexed by bank / bank_d2 (0=A .. 3=D)
  int idle_tab [4] = '{2, 3, 0, 1};
  int t0s0_tab [4] = '{3, 3, 1, 1};
  int t0s1_tab [4] = '{2, 2, 0, 0};
  int t0sel_tab[4] = '{0, 1, 0, 1};
  int t1s0_tab [4] = '{2, 0, 0, 2};
  int t1s1_tab [4] = '{1, 3, 3, 1};
  int t1sel_tab[4] = '{1, 0, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bank after m enabled edges since restart
  function automatic int bank_at(input int m);
    return (m <= 0) ? 0 : (m / 1024) % 4;
  endfunction

  function automatic int ph_at(input int m);
    return bank_at(m - 3) % 2;
  endfunction

  function automatic int drd_at(input int m);
    return (1021 + m) % 1024;
  endfunction

  function automatic int dwr_at(input int m);
    return (2 - m + 16 * 1024) % 1024;
  endfunction

  // Enable is already high; edge k=1 is the first enabled edge after a restart.
  task automatic run_window(input string tag, input int n, input bit spot);
    int bad_wr, bad_addr, bad_fsm, bad_tsel, bad_disp, bad_frame;
    bad_wr = 0; bad_addr = 0; bad_fsm = 0; bad_tsel = 0; bad_disp = 0; bad_frame = 0;
    for (int k = 1; k <= n; k++) begin
      int wb, j, row, ph1, es, ef;
      int ea[4];
      logic [9:0] oa[4];
      logic [3:0] ewr;
      logic [9:0] ed0, ed1;
      tick();
      wb  = bank_at(k - 1);
      j   = (k - 1) % 1024;
      ewr = 4'(1 << wb);
      for (int i = 0; i < 4; i++)
        ea[i] = (i == wb) ? j : (i == idle_tab[wb]) ? 0 : 1023 - j;
      oa[0] = bus.addr_a; oa[1] = bus.addr_b; oa[2] = bus.addr_c; oa[3] = bus.addr_d;
      if ({bus.wr_d, bus.wr_c, bus.wr_b, bus.wr_a} !== ewr) bad_wr++;
      for (int i = 0; i < 4; i++)
        if (oa[i] !== 10'(ea[i])) bad_addr++;
      es = (k >= 2051) ? 2 : 1;
      if ({bus.state_o, bus.tbu0_en, bus.tbu1_en} !== {2'(es), k >= 2051, k >= 3075}) bad_fsm++;
      row = bank_at(k - 3);
      if ({bus.tbu0_src0, bus.tbu0_src1, bus.tbu0_sel, bus.tbu1_src0, bus.tbu1_src1, bus.tbu1_sel} !==
          {2'(t0s0_tab[row]), 2'(t0s1_tab[row]), 1'(t0sel_tab[row]),
           2'(t1s0_tab[row]), 2'(t1s1_tab[row]), 1'(t1sel_tab[row])}) bad_tsel++;
      ph1 = ph_at(k - 1);
      ed0 = 10'(ph1 ? dwr_at(k - 1) : drd_at(k - 1));
      ed1 = 10'(ph1 ? drd_at(k - 1) : dwr_at(k - 1));
      if ({bus.addr_disp0, bus.addr_disp1, bus.out_sel} !== {ed0, ed1, 1'(ph_at(k - 2))}) bad_disp++;
`ifdef FRAME_CNT_EN
      ef = k / 4096;
`else
      ef = 0;
`endif
      if (bus.frame_cnt !== 16'(ef)) bad_frame++;
      if (spot) begin
        if (k == 1) begin
          check("first_addr_a", bus.addr_a, 0);
          check("first_addr_b_rdcnt", bus.addr_b, 1023);
          check("first_disp0_rdcnt", bus.addr_disp0, 1021);
          check("first_disp1_wrcnt", bus.addr_disp1, 2);
        end
        if (k == 1024) check("last_wr_a", {bus.wr_b, bus.wr_a, bus.addr_a}, {2'b01, 10'd1023});
        if (k == 1025) check("first_wr_b", {bus.wr_b, bus.wr_a, bus.addr_b}, {2'b10, 10'd0});
        if (k == 1028) check("disp_swap", {bus.addr_disp0, bus.addr_disp1}, {10'd1023, 10'd0});
        if (k == 1500) begin
          check("route_d2_1_tbu0", {bus.tbu0_src0, bus.tbu0_src1, bus.tbu0_sel}, {2'd3, 2'd2, 1'b1});
          check("route_d2_1_tbu1", {bus.tbu1_src0, bus.tbu1_src1, bus.tbu1_sel}, {2'd0, 2'd3, 1'b0});
          check("idle_addr_d", bus.addr_d, 0);
        end
        if (k == 2050) check("tbu0_en_pre", {bus.tbu0_en, bus.state_o}, {1'b0, 2'd1});
        if (k == 2051) check("tbu0_en_rise", {bus.tbu0_en, bus.state_o}, {1'b1, 2'd2});
        if (k == 3074) check("tbu1_en_pre", bus.tbu1_en, 0);
        if (k == 3075) check("tbu1_en_rise", bus.tbu1_en, 1);
`ifdef FRAME_CNT_EN
        if (k == 8192) check("frame_cnt_8192", bus.frame_cnt, 2);
`else
        if (k == 8192) check("frame_cnt_8192", bus.frame_cnt, 0);
`endif
      end
    end
    check({tag, "_wr_onehot"}, bad_wr, 0);
    check({tag, "_bank_addr"}, bad_addr, 0);
    check({tag, "_fsm_tbu_en"}, bad_fsm, 0);
    check({tag, "_tbu_route"}, bad_tsel, 0);
    check({tag, "_disp"}, bad_disp, 0);
    check({tag, "_frame_cnt"}, bad_frame, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_wr", {bus.wr_a, bus.wr_b, bus.wr_c, bus.wr_d}, 0);
    check("rst_tbu_en", {bus.tbu0_en, bus.tbu1_en}, 0);
    check("rst_state", bus.state_o, 0);
    check("rst_addr", {bus.addr_a, bus.addr_b, bus.addr_c, bus.addr_d}, 0);
    check("rst_disp", {bus.addr_disp0, bus.addr_disp1, bus.out_sel}, 0);
    check("rst_frame", bus.frame_cnt, 0);

    rst = 1'b1;
    bus.enable = 1'b1;
    run_window("rot", 9215, 1'b1);

    // Drop enable on the cycle wr_cnt = 1023: the flush must beat the bank increment.
    bus.enable = 1'b0;
    tick();
    check("flush_wr", {bus.wr_a, bus.wr_b, bus.wr_c, bus.wr_d}, 0);
    check("flush_state", bus.state_o, 0);
    check("flush_tbu_en", {bus.tbu0_en, bus.tbu1_en}, 0);
    check("flush_addr_hold", {bus.addr_a, bus.addr_b, bus.addr_c}, {10'd1022, 10'd1, 10'd0});
    repeat (2) tick();
    check("flush_idle_wr", {bus.wr_a, bus.wr_b, bus.wr_c, bus.wr_d, bus.state_o}, 0);
    bus.enable = 1'b1;
    run_window("reflush", 2100, 1'b0);

    // Reset mid-frame with enable still high
    rst = 1'b0;
    tick();
    check("midrst_state_wr", {bus.state_o, bus.wr_a, bus.wr_b, bus.wr_c, bus.wr_d}, 0);
    check("midrst_tbu", {bus.tbu0_en, bus.tbu1_en, bus.tbu0_src0, bus.tbu0_src1}, 0);
    check("midrst_addr", {bus.addr_a, bus.addr_b, bus.addr_disp0}, 0);
    rst = 1'b1;
    run_window("postrst", 40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
